// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU operation sequencer.
// Latencies are total datapath cycles; illegal op codes take a single cycle.
package fpu_pkg;

  typedef enum logic [2:0] {
    FPU_ADD  = 3'd0,
    FPU_SUB  = 3'd1,
    FPU_MULT = 3'd2,
    FPU_DIV  = 3'd3,
    FPU_SQRT = 3'd4
  } fpu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  op;
    logic [2:0]  rnd;
    logic [3:0]  tag;
  } fpu_req_t;

  localparam int unsigned FPU_LAT [5] = '{32'd2, 32'd2, 32'd3, 32'd6, 32'd6};
  localparam logic [31:0] FPU_QNAN    = 32'h7FC0_0000;

  localparam int STAT_ZERO    = 0;
  localparam int STAT_INF     = 1;
  localparam int STAT_INVALID = 2;
  localparam int STAT_TINY    = 3;
  localparam int STAT_HUGE    = 4;
  localparam int STAT_INEXACT = 5;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= 3'd4);
  endfunction

  // Countdown start value for EXEC; illegal ops leave EXEC after one cycle.
  function automatic logic [3:0] lat_load(input logic [2:0] op);
    logic [3:0] val;
    case (op)
      FPU_ADD:  val = 4'(FPU_LAT[0] - 32'd1);
      FPU_SUB:  val = 4'(FPU_LAT[1] - 32'd1);
      FPU_MULT: val = 4'(FPU_LAT[2] - 32'd1);
      FPU_DIV:  val = 4'(FPU_LAT[3] - 32'd1);
      FPU_SQRT: val = 4'(FPU_LAT[4] - 32'd1);
      default:  val = 4'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// Request queue for the FPU sequencer: DEPTH entries of WIDTH bits.
// Status flags decode the registered count only.
module fpu_req_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 74
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(0));
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign pop_data  = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r <= (wr_ptr_r == PW'(DEPTH - 1)) ? '0 : wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PW'(DEPTH - 1)) ? '0 : rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Queues FPU requests, presents each to the datapath for its fixed latency,
// and holds the captured response until the consumer takes it.
module fpu_op_sequencer
  import fpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [2:0]  req_rnd,
  input  logic [3:0]  req_tag,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  output logic [2:0]  dp_op,
  output logic [2:0]  dp_rnd,
  input  logic [31:0] dp_result,
  input  logic [7:0]  dp_status,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [7:0]  rsp_status,
  output logic [3:0]  rsp_tag,
  output logic        busy
);

  seq_state_e  state_r;
  logic [3:0]  cnt_r;
  logic [3:0]  cur_tag_r;
  logic        cur_legal_r;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic        push_s;
  logic        pop_s;
  fpu_req_t    push_data_s;
  fpu_req_t    head_s;

  assign push_data_s.rs1 = req_rs1;
  assign push_data_s.rs2 = req_rs2;
  assign push_data_s.op  = req_op;
  assign push_data_s.rnd = req_rnd;
  assign push_data_s.tag = req_tag;

  assign req_ready = !fifo_full_s;
  assign push_s    = req_valid && !fifo_full_s;
  assign pop_s     = (state_r == ST_IDLE) && !fifo_empty_s;
  assign busy      = !fifo_empty_s || (state_r != ST_IDLE);

  fpu_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fpu_req_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Sequencer FSM with its operand and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      cur_tag_r   <= 4'd0;
      cur_legal_r <= 1'b0;
      dp_a        <= 32'd0;
      dp_b        <= 32'd0;
      dp_op       <= 3'd0;
      dp_rnd      <= 3'd0;
      rsp_valid   <= 1'b0;
      rsp_result  <= 32'd0;
      rsp_status  <= 8'd0;
      rsp_tag     <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            dp_a        <= head_s.rs1;
            dp_b        <= head_s.rs2;
            dp_op       <= head_s.op;
            dp_rnd      <= head_s.rnd;
            cur_tag_r   <= head_s.tag;
            cur_legal_r <= op_legal(head_s.op);
            cnt_r       <= lat_load(head_s.op);
            state_r     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_r == 4'd0) begin
            // Illegal ops never trust the datapath; they report a quiet NaN.
            if (cur_legal_r) begin
              rsp_result <= dp_result;
              rsp_status <= dp_status;
            end else begin
              rsp_result <= FPU_QNAN;
              rsp_status <= 8'd1 << STAT_INVALID;
            end
            rsp_tag   <= cur_tag_r;
            rsp_valid <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
